dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle CPU: word RAM with asynchronous read plus a
// 16-byte MMIO window (LED, free-running cycle counter, store counter, tohost mailbox).
module dmem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_w,
   output logic [31:0] rdata,
   output logic [15:0] led,
   output logic        done,
   output logic        err
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

   localparam logic [1:0] REG_LED    = 2'd0;
   localparam logic [1:0] REG_CYCLE  = 2'd1;
   localparam logic [1:0] REG_STORES = 2'd2;
   localparam logic [1:0] REG_TOHOST = 2'd3;

   logic [31:0] mem_q [DEPTH];

   logic [15:0] led_q, led_d;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] stores_q, stores_d;
   logic [31:0] tohost_q, tohost_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic [31:0]   mmio_off;
   logic          ram_sel;
   logic          mmio_sel;
   logic          misal;
   logic [1:0]    reg_sel;
   logic [AW-1:0] ram_idx;
   logic          tohost_ign;
   logic          wr_ok;
   logic          wr_bad;

   // Unsigned offset compare also rejects addresses below the window (they wrap high).
   assign mmio_off = addr - MMIO_BASE;
   assign mmio_sel = (mmio_off < 32'd16);
   assign ram_sel  = (addr < RAM_BYTES);
   assign reg_sel  = mmio_off[3:2];
   assign ram_idx  = addr[AW+1:2];
   assign misal    = (addr[1:0] != 2'b00);

   // A second TOHOST write is dropped silently: neither stored nor counted, and not an error.
   assign tohost_ign = mmio_sel && (reg_sel == REG_TOHOST) && done_q;
   assign wr_ok      = mem_w && !misal && (ram_sel || mmio_sel) && !tohost_ign;
   assign wr_bad     = mem_w && (misal || !(ram_sel || mmio_sel));

   always_comb begin
      led_d    = led_q;
      cycle_d  = cycle_q + 32'd1;
      stores_d = stores_q + {31'b0, wr_ok};
      tohost_d = tohost_q;
      done_d   = done_q;
      err_d    = err_q | wr_bad;
      if (wr_ok && mmio_sel) begin
         case (reg_sel)
            REG_LED:    led_d    = wdata[15:0];
            REG_CYCLE:  cycle_d  = wdata;
            REG_STORES: stores_d = wdata;
            default: begin
               tohost_d = wdata;
               done_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q    <= 16'h0;
         cycle_q  <= 32'h0;
         stores_q <= 32'h0;
         tohost_q <= 32'h0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         led_q    <= led_d;
         cycle_q  <= cycle_d;
         stores_q <= stores_d;
         tohost_q <= tohost_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // RAM contents survive reset; only the write is blocked while rst is high.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok && ram_sel) begin
         mem_q[ram_idx] <= wdata;
      end
   end

   always_comb begin
      rdata = 32'h0;
      if (ram_sel) begin
         rdata = mem_q[ram_idx];
      end else if (mmio_sel) begin
         case (reg_sel)
            REG_LED:    rdata = {16'h0, led_q};
            REG_CYCLE:  rdata = cycle_q;
            REG_STORES: rdata = stores_q;
            default:    rdata = tohost_q;
         endcase
      end
   end

   assign led  = led_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: inputs change on the falling edge, combinational
// rdata is sampled 1 time unit later, so writes land on the following rising edge.
module tb_dmem_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_w;
   logic [31:0] rdata;
   logic [15:0] led;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(1024), .MMIO_BASE(BASE)) dut (
      .clk   (clk),
      .rst   (rst),
      .addr  (addr),
      .wdata (wdata),
      .mem_w (mem_w),
      .rdata (rdata),
      .led   (led),
      .done  (done),
      .err   (err)
   );

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      mem_w = 1'b1;
      cyc();
      mem_w = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_w = 1'b0; addr = '0; wdata = '0;
      repeat (2) cyc();
      rst = 1'b0;
      wr(32'h10, 32'h1111_1111);
      // writes presented during reset must be ignored
      rst = 1'b1;
      addr = 32'h10; wdata = 32'hBAD0_BAD0; mem_w = 1'b1;
      cyc();
      addr = BASE; wdata = 32'h0000_FFFF;
      cyc();
      mem_w = 1'b0;
      cyc();
      addr = BASE + 4; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_cycle_held got=%h want=%h", rdata, 32'h0); end
      rst = 1'b0;
      #1;
      total++; if (led !== 16'h0) begin bad++; $display("FAIL reset_led got=%h want=%h", led, 16'h0); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      addr = BASE; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_led_rd got=%h want=%h", rdata, 32'h0); end
      addr = BASE + 4; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_cycle_rd got=%h want=%h", rdata, 32'h0); end
      addr = BASE + 8; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_stores_rd got=%h want=%h", rdata, 32'h0); end
      addr = BASE + 12; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_tohost_rd got=%h want=%h", rdata, 32'h0); end
      addr = 32'h10; #1;
      total++; if (rdata !== 32'h1111_1111) begin bad++; $display("FAIL reset_ram_kept got=%h want=%h", rdata, 32'h1111_1111); end
   endtask

   task automatic test_ram();
      addr = 32'h10; wdata = 32'hDEAD_BEEF; mem_w = 1'b1; #1;
      total++; if (rdata !== 32'h1111_1111) begin bad++; $display("FAIL ram_prewrite got=%h want=%h", rdata, 32'h1111_1111); end
      cyc();
      mem_w = 1'b0; #1;
      total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_postwrite got=%h want=%h", rdata, 32'hDEAD_BEEF); end
      addr = BASE + 8; #1;
      total++; if (rdata !== 32'd1) begin bad++; $display("FAIL ram_stores got=%0d want=1", rdata); end
      wr(32'hFFC, 32'hA5A5_0001); #1;
      total++; if (rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL ram_top_word got=%h want=%h", rdata, 32'hA5A5_0001); end
      // back-to-back stores on consecutive cycles
      addr = 32'h20; wdata = 32'd1; mem_w = 1'b1;
      cyc();
      addr = 32'h24; wdata = 32'd2;
      cyc();
      mem_w = 1'b0;
      addr = 32'h20; #1;
      total++; if (rdata !== 32'd1) begin bad++; $display("FAIL b2b_first got=%h want=%h", rdata, 32'd1); end
      addr = 32'h24; #1;
      total++; if (rdata !== 32'd2) begin bad++; $display("FAIL b2b_second got=%h want=%h", rdata, 32'd2); end
      wr(BASE + 8, 32'd100); #1;
      total++; if (rdata !== 32'd100) begin bad++; $display("FAIL stores_load got=%0d want=100", rdata); end
      wr(32'h28, 32'd3);
      addr = BASE + 8; #1;
      total++; if (rdata !== 32'd101) begin bad++; $display("FAIL stores_after_load got=%0d want=101", rdata); end
   endtask

   task automatic test_cycle();
      rst = 1'b1;
      repeat (2) cyc();
      addr = BASE + 4; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL cycle_in_rst got=%h want=%h", rdata, 32'h0); end
      rst = 1'b0;
      repeat (5) cyc();
      #1;
      total++; if (rdata !== 32'd5) begin bad++; $display("FAIL cycle_after5 got=%0d want=5", rdata); end
      wr(BASE + 4, 32'hFFFF_FFFE); #1;
      total++; if (rdata !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cycle_load got=%h want=%h", rdata, 32'hFFFF_FFFE); end
      cyc(); #1;
      total++; if (rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cycle_max got=%h want=%h", rdata, 32'hFFFF_FFFF); end
      cyc(); #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL cycle_wrap got=%h want=%h", rdata, 32'h0); end
   endtask

   task automatic test_led_misaligned();
      wr(BASE, 32'h1234_ABCD); #1;
      total++; if (led !== 16'hABCD) begin bad++; $display("FAIL led_out got=%h want=%h", led, 16'hABCD); end
      total++; if (rdata !== 32'h0000_ABCD) begin bad++; $display("FAIL led_rd got=%h want=%h", rdata, 32'h0000_ABCD); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL led_err got=%b want=0", err); end
      addr = BASE + 8; #1;
      total++; if (rdata !== 32'd2) begin bad++; $display("FAIL led_stores got=%0d want=2", rdata); end
      wr(32'h12, 32'h0BAD_F00D); #1;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL misal_err got=%b want=1", err); end
      total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL misal_ram got=%h want=%h", rdata, 32'hDEAD_BEEF); end
      addr = BASE + 8; #1;
      total++; if (rdata !== 32'd2) begin bad++; $display("FAIL misal_stores got=%0d want=2", rdata); end
   endtask

   task automatic test_unmapped();
      rst = 1'b1;
      cyc();
      rst = 1'b0; #1;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL unmap_err_clear got=%b want=0", err); end
      addr = 32'h4000_0000; wdata = 32'd5; mem_w = 1'b1; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmap_rd got=%h want=%h", rdata, 32'h0); end
      cyc();
      mem_w = 1'b0; #1;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL unmap_err got=%b want=1", err); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmap_rd_after got=%h want=%h", rdata, 32'h0); end
      addr = 32'h1000; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmap_ram_end got=%h want=%h", rdata, 32'h0); end
      repeat (3) cyc();
      #1;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL unmap_err_sticky got=%b want=1", err); end
      addr = BASE + 8; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmap_stores got=%0d want=0", rdata); end
      rst = 1'b1;
      cyc();
      rst = 1'b0; #1;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL unmap_err_rst got=%b want=0", err); end
   endtask

   task automatic test_tohost();
      wr(BASE + 12, 32'd7); #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL tohost_done got=%b want=1", done); end
      total++; if (rdata !== 32'd7) begin bad++; $display("FAIL tohost_first got=%0d want=7", rdata); end
      wr(BASE + 12, 32'd9); #1;
      total++; if (rdata !== 32'd7) begin bad++; $display("FAIL tohost_second got=%0d want=7", rdata); end
      rst = 1'b1;
      cyc();
      rst = 1'b0; #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL tohost_done_rst got=%b want=0", done); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL tohost_rst got=%h want=%h", rdata, 32'h0); end
      addr = 32'h10; #1;
      total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tohost_ram_kept got=%h want=%h", rdata, 32'hDEAD_BEEF); end
   endtask

   // Mimics the CPU's load/add/store loop summing 1..10 into RAM word 0x100.
   task automatic test_program();
      logic [31:0] acc;
      wr(32'h100, 32'd0);
      for (int i = 1; i <= 10; i++) begin
         addr = 32'h100; #1;
         acc = rdata;
         wr(32'h100, acc + 32'(i)); #1;
         total++; if (err !== 1'b0) begin bad++; $display("FAIL prog_err step=%0d got=%b want=0", i, err); end
      end
      addr = 32'h100; #1;
      total++; if (rdata !== 32'd55) begin bad++; $display("FAIL prog_sum got=%0d want=55", rdata); end
      acc = rdata;
      wr(BASE + 12, acc); #1;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL prog_done got=%b want=1", done); end
      total++; if (rdata !== 32'd55) begin bad++; $display("FAIL prog_tohost got=%0d want=55", rdata); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL prog_err_end got=%b want=0", err); end
      addr = BASE + 8; #1;
      total++; if (rdata !== 32'd12) begin bad++; $display("FAIL prog_stores got=%0d want=12", rdata); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_cycle();
      test_led_misaligned();
      test_unmapped();
      test_tohost();
      test_program();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
